// File: rtl/d_bus_pkg.sv
// Shared types and widths for the per-core data-bus requester.
package d_bus_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // One latched core transaction; we == 0 means a read.
    typedef struct packed {
        logic [BE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_req_timer.sv
// Clear/enable counter that flags a stalled bus transaction after TIMEOUT_CYCLES.
module bus_req_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_c_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Hold at the terminal count; the requester leaves REQ/XFER on expiry anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_c_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/d_bus_requester.sv
// Per-core data-bus client: core request -> arbiter RQ/GRANT/Ready handshake.
// Optional stall abort is compiled in with BUS_REQ_TIMEOUT_EN.
import d_bus_pkg::*;

module d_bus_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic [BE_W-1:0]   cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic              cpu_err_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              bus_rq_o,
    input  logic              bus_grant_i,
    input  logic              datamem_ready_i,
    input  logic [DATA_W-1:0] datamem_in_i,
    output logic              datamem_read_o,
    output logic [BE_W-1:0]   datamem_write_o,
    output logic [ADDR_W-1:0] datamem_address_o,
    output logic [DATA_W-1:0] datamem_out_o
);

    if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 4");
    end

    state_e            state_q, state_d;
    bus_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              rq_q, rq_d;
    logic              expire_c;
    logic              drive_c;
    logic              is_read_c;

`ifdef BUS_REQ_TIMEOUT_EN
    logic timer_clr_c;
    logic timer_en_c;

    assign timer_clr_c = (state_q == IDLE) && cpu_req_i;
    assign timer_en_c  = (state_q == REQ) || (state_q == XFER);

    bus_req_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (timer_clr_c),
        .en_i      (timer_en_c),
        .expire_c_o(expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    assign is_read_c = (req_q.we == '0);

    // Bus is driven only while granted in XFER so cores can be OR-combined.
    assign drive_c           = (state_q == XFER) && bus_grant_i;
    assign datamem_read_o    = drive_c && is_read_c;
    assign datamem_write_o   = drive_c ? req_q.we    : '0;
    assign datamem_address_o = drive_c ? req_q.addr  : '0;
    assign datamem_out_o     = drive_c ? req_q.wdata : '0;

    assign cpu_ack_o   = ack_q;
    assign cpu_err_o   = err_q;
    assign cpu_rdata_o = rdata_q;
    assign bus_rq_o    = rq_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    req_d   = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (expire_c) begin
                    state_d = RELEASE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else if (bus_grant_i) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (bus_grant_i && datamem_ready_i) begin
                    if (is_read_c) begin
                        rdata_d = datamem_in_i;
                    end
                    state_d = RELEASE;
                    ack_d   = 1'b1;
                end else if (expire_c) begin
                    state_d = RELEASE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else if (!bus_grant_i) begin
                    state_d = REQ;
                end
            end
            RELEASE: begin
                // Wait out a lingering grant/Ready so it cannot complete the next request.
                if (!bus_grant_i && !datamem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rq_d = (state_d == REQ) || (state_d == XFER);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rq_q    <= rq_d;
        end
    end

endmodule
